// File: rtl/spi_arbiter.sv
// Two-client round-robin arbiter in front of a single SPI engine: pushes each
// owner's command header into the TX FIFO, kicks the engine, and drains RX bytes.
module spi_arbiter #(
  parameter int DATA      = 8,
  parameter int HDR_BYTES = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req,
  input  logic [1:0]                    req_op,
  input  logic [31:0]                   req_len,
  input  logic [2*HDR_BYTES*DATA-1:0]   req_hdr,
  output logic [1:0]                    gnt,
  output logic [1:0]                    done,
  output logic [DATA-1:0]               rx_data,
  output logic [1:0]                    rx_valid,
  output logic [15:0]                   len,
  output logic                          op,
  output logic                          work,
  input  logic                          busy,
  output logic [DATA-1:0]               wdata,
  output logic                          wr,
  input  logic                          full,
  input  logic [DATA-1:0]               rdata,
  output logic                          rd,
  input  logic                          empty
);

  localparam int HW = HDR_BYTES * DATA;
  localparam int IW = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(HDR_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_START,
    ST_WAIT_BUSY,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t          state, state_nxt;
  logic            owner;
  logic            last;
  logic            op_q;
  logic [15:0]     len_q;
  logic [HW-1:0]   hdr_q;
  logic [IW-1:0]   idx;
  logic            rd_q;
  logic            winner;

  // On a tie the client that was not served last wins; otherwise whoever asks.
  assign winner = (req == 2'b11) ? ~last : req[1];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (|req) state_nxt = ST_HDR;
      ST_HDR:       if (wr && idx == IDX_LAST) state_nxt = ST_START;
      ST_START:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (busy) state_nxt = ST_RUN;
      ST_RUN:       if (!busy) state_nxt = ST_DRAIN;
      ST_DRAIN:     if (empty && !rd_q) state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    gnt   = '0;
    done  = '0;
    len   = '0;
    op    = 1'b0;
    work  = 1'b0;
    wr    = 1'b0;
    wdata = '0;
    rd    = 1'b0;
    if (state != ST_IDLE) begin
      gnt[owner] = 1'b1;
      len        = len_q;
      op         = op_q;
    end
    case (state)
      ST_HDR: begin
        wr    = !full;
        wdata = hdr_q[HW-1 -: DATA];
      end
      ST_START:         work = 1'b1;
      ST_RUN, ST_DRAIN: rd   = !empty && !rd_q;
      ST_DONE:          done[owner] = 1'b1;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      op_q     <= 1'b0;
      len_q    <= '0;
      hdr_q    <= '0;
      idx      <= '0;
      rd_q     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= '0;
    end else begin
      state    <= state_nxt;
      rd_q     <= rd;
      rx_valid <= '0;
      // rdata is valid the cycle after rd; write-op bytes never raise rx_valid.
      if (rd_q) begin
        rx_data <= rdata;
        if (!op_q) rx_valid[owner] <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (|req) begin
            owner <= winner;
            op_q  <= req_op[winner];
            len_q <= winner ? req_len[31:16] : req_len[15:0];
            hdr_q <= winner ? req_hdr[2*HW-1:HW] : req_hdr[HW-1:0];
            idx   <= '0;
          end
        end
        ST_HDR: begin
          // Shift only on an accepted write so a stall neither drops nor repeats a byte.
          if (wr) begin
            hdr_q <= hdr_q << DATA;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end
        end
        ST_DONE: last <= owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: behavioural TX/RX FIFOs and SPI engine,
// a table of single transactions plus tie, stall and reset sequences.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  req_op = '0;
  logic [31:0] req_len = '0;
  logic [47:0] req_hdr = '0;
  logic [1:0]  gnt, done, rx_valid;
  logic [7:0]  rx_data, wdata;
  logic [15:0] len;
  logic        op, work, wr, rd;
  logic        busy = 1'b0;
  logic        full = 1'b0;
  logic [7:0]  rdata = '0;
  logic        empty = 1'b1;

  spi_arbiter #(.DATA(8), .HDR_BYTES(3)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_len(req_len),
    .req_hdr(req_hdr), .gnt(gnt), .done(done), .rx_data(rx_data),
    .rx_valid(rx_valid), .len(len), .op(op), .work(work), .busy(busy),
    .wdata(wdata), .wr(wr), .full(full), .rdata(rdata), .rd(rd), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // RX FIFO model: rd seen at negedge pops at the following posedge.
  logic [7:0] rx_fifo[$];
  logic [7:0] rx_src[$];
  initial begin
    logic rd_pend;
    forever begin
      @(negedge clk);
      rd_pend = rd;
      @(posedge clk);
      #1;
      if (rd_pend && rx_fifo.size() > 0) rdata = rx_fifo.pop_front();
      if (rx_src.size() > 0) rx_fifo.push_back(rx_src.pop_front());
      empty = (rx_fifo.size() == 0);
    end
  end

  // SPI engine model: busy a little after work, produces eng_n bytes.
  int         eng_n = 0;
  bit         eng_early = 1'b0;
  logic [7:0] eng_base = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (work) begin
        repeat (2) @(negedge clk);
        busy = 1'b1;
        for (int k = 0; k < eng_n; k++) rx_src.push_back(eng_base + 8'(k));
        @(negedge clk);
        for (int c = 0; c < 100 && rx_src.size() != 0; c++) @(negedge clk);
        if (!eng_early)
          for (int c = 0; c < 100 && rx_fifo.size() != 0; c++) @(negedge clk);
        busy = 1'b0;
      end
    end
  end

  // Monitor; logs are cleared when the test bumps clr_cnt.
  int         clr_cnt = 0, clr_seen = 0;
  logic [7:0] tx_log[$];
  logic [7:0] rx_log[$];
  logic [1:0] gnt_order[$];
  int         wr_full_n = 0, work_n = 0, gnt_bad = 0, idle_bad = 0, unstable_n = 0;
  int         rxv_n[2] = '{0, 0};
  int         done_n[2] = '{0, 0};
  int         done_fifo = 0;
  logic [1:0] done_gnt = '0, gnt_first = '0, prev_gnt = '0;
  logic [15:0] work_len = '0;
  logic       work_op = 1'b0, work_seen = 1'b0;

  always @(negedge clk) begin
    if (clr_cnt != clr_seen) begin
      clr_seen = clr_cnt;
      tx_log.delete(); rx_log.delete(); gnt_order.delete();
      wr_full_n = 0; work_n = 0; gnt_bad = 0; idle_bad = 0; unstable_n = 0;
      rxv_n = '{0, 0}; done_n = '{0, 0}; done_fifo = 0;
      done_gnt = '0; gnt_first = '0; work_len = '0; work_op = 1'b0; work_seen = 1'b0;
    end
    if (!rst) begin
      if (wr) begin
        if (full) wr_full_n++;
        else tx_log.push_back(wdata);
      end
      if (work_seen && (len != work_len || op != work_op)) unstable_n++;
      if (work) begin
        work_n++; work_len = len; work_op = op; work_seen = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        if (rx_valid[i]) begin rxv_n[i]++; rx_log.push_back(rx_data); end
        if (done[i]) begin
          done_n[i]++;
          done_fifo = rx_fifo.size() + rx_src.size();
          done_gnt = gnt;
          work_seen = 1'b0;
        end
      end
      if (gnt == 2'b11) gnt_bad++;
      if (gnt == 2'b00 && (len != 0 || op || work || wr || rd || done != 0)) idle_bad++;
      if (prev_gnt == 2'b00 && gnt != 2'b00) begin
        gnt_first = gnt;
        gnt_order.push_back(gnt);
      end
    end
    prev_gnt = gnt;
  end

  task automatic clear_logs();
    @(posedge clk);
    #1 clr_cnt++;
    @(negedge clk);
  endtask

  task automatic wait_any_done(output logic [1:0] d);
    int c = 0;
    while (done == 2'b00 && c < 300) begin @(negedge clk); c++; end
    d = done;
  endtask

  task automatic run_txn(input int cli, input logic o, input logic [15:0] l,
                         input logic [23:0] h, input int n, input bit early,
                         input bit stall, input logic [7:0] base);
    logic [1:0] d;
    int c;
    clear_logs();
    eng_n = n; eng_early = early; eng_base = base;
    req_op[cli] = o;
    req_len[16*cli +: 16] = l;
    req_hdr[24*cli +: 24] = h;
    req[cli] = 1'b1;
    if (stall) begin
      c = 0;
      while (!(wr && !full) && c < 100) begin @(negedge clk); c++; end
      check("stall_arm", c < 100, 1);
      @(posedge clk); #1 full = 1'b1;
      repeat (4) @(posedge clk);
      #1 full = 1'b0;
      @(negedge clk);
    end
    wait_any_done(d);
    check("done_owner", d, 2'b01 << cli);
    req[cli] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int          cli;
    logic        op;
    logic [15:0] len;
    logic [23:0] hdr;
    int          nrx;
    bit          early;
    bit          stall;
    logic [7:0]  base;
    int          exp_rxv;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [1:0] d;
    int c;
    vecs[0] = '{0, 1'b0, 16'd40, 24'h001900, 5, 1'b0, 1'b0, 8'h01, 5};
    vecs[1] = '{1, 1'b1, 16'd3,  24'hA1B2C3, 3, 1'b0, 1'b0, 8'h20, 0};
    vecs[2] = '{0, 1'b0, 16'd16, 24'h5A0F33, 4, 1'b1, 1'b0, 8'h30, 4};
    vecs[3] = '{1, 1'b0, 16'd0,  24'h123456, 0, 1'b0, 1'b0, 8'h00, 0};
    vecs[4] = '{1, 1'b0, 16'd8,  24'hFFEE01, 2, 1'b0, 1'b1, 8'h50, 2};

    repeat (3) @(negedge clk);
    check("reset_outputs", {gnt, done, rx_valid, rx_data, len, op, work, wr, wdata, rd}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Tie right after reset, requests held: 0,1,0,1.
    clear_logs();
    eng_n = 1; eng_early = 1'b0; eng_base = 8'h40;
    req_op = 2'b00; req_len = {16'd2, 16'd1}; req_hdr = {24'hC1C2C3, 24'hB1B2B3};
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_any_done(d);
      check("tie_done_order", d, (t % 2 == 0) ? 2'b01 : 2'b10);
      if (t == 3) req = 2'b00;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("tie_gnt_count", gnt_order.size(), 4);
    if (gnt_order.size() > 0) check("tie_first_gnt", gnt_order[0], 2'b01);
    if (gnt_order.size() > 1) check("tie_second_gnt", gnt_order[1], 2'b10);
    check("tie_gnt_onehot", gnt_bad, 0);

    for (int v = 0; v < 5; v++) begin
      run_txn(vecs[v].cli, vecs[v].op, vecs[v].len, vecs[v].hdr, vecs[v].nrx,
              vecs[v].early, vecs[v].stall, vecs[v].base);
      check("tx_count", tx_log.size(), 3);
      for (int b = 0; b < 3 && b < tx_log.size(); b++)
        check("tx_byte", tx_log[b], 8'(vecs[v].hdr >> (8 * (2 - b))));
      check("wr_while_full", wr_full_n, 0);
      check("work_pulses", work_n, 1);
      check("work_len", work_len, vecs[v].len);
      check("work_op", work_op, vecs[v].op);
      check("rx_valid_count", rxv_n[vecs[v].cli], vecs[v].exp_rxv);
      check("rx_valid_other", rxv_n[1 - vecs[v].cli], 0);
      for (int k = 0; k < rx_log.size(); k++)
        check("rx_data", rx_log[k], vecs[v].base + 8'(k));
      check("done_count", done_n[vecs[v].cli], 1);
      check("done_other", done_n[1 - vecs[v].cli], 0);
      check("fifo_empty_at_done", done_fifo, 0);
      check("gnt_at_done", done_gnt, 2'b01 << vecs[v].cli);
      check("gnt_first", gnt_first, 2'b01 << vecs[v].cli);
      check("gnt_onehot", gnt_bad, 0);
      check("idle_outputs", idle_bad, 0);
      check("len_op_stable", unstable_n, 0);
    end

    // Reset during ST_RUN after client 0 was served last.
    run_txn(0, 1'b0, 16'd4, 24'h0A0B0C, 1, 1'b0, 1'b0, 8'h60);
    clear_logs();
    eng_n = 8; eng_early = 1'b0; eng_base = 8'h70;
    req_op[1] = 1'b0; req_len[31:16] = 16'd8; req_hdr[47:24] = 24'h0D0E0F;
    req[1] = 1'b1;
    c = 0;
    while (!rd && c < 200) begin @(negedge clk); c++; end
    check("rst_reach_run", rd, 1);
    rst = 1'b1;
    req[1] = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {gnt, done, rx_valid, rx_data, len, op, work, wr, wdata, rd}, 64'h0);
    rst = 1'b0;
    rx_src.delete();
    rx_fifo.delete();
    c = 0;
    while (busy && c < 200) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    check("rst_no_done", done_n[1], 0);

    clear_logs();
    eng_n = 1; eng_early = 1'b0; eng_base = 8'h80;
    req_op = 2'b00;
    req = 2'b11;
    wait_any_done(d);
    check("post_rst_first", d, 2'b01);
    req[0] = 1'b0;
    @(negedge clk);
    wait_any_done(d);
    check("post_rst_second", d, 2'b10);
    req = 2'b00;
    repeat (3) @(negedge clk);
    check("post_rst_rx_count", rxv_n[0] + rxv_n[1], 2);
    check("post_rst_tx_count", tx_log.size(), 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
